// File: rtl/olo_fix_tutorial_ctrl_sequencer.sv
// olo_fix_tutorial_ctrl_sequencer
//  Sequencer and configuration front-end for the fixed-point PI controller.
//  Generates the sample strobe, issues one sample at a time to the controller,
//  watches for its result and swaps Ki/Kp/ILim only while the pipeline is empty.
//  Optional feature macro: OLO_FIX_SEQ_INT_CLEAR_EN (pulse Ctrl_IntClr when new
//  gains become active so the integrator restarts from zero).
module olo_fix_tutorial_ctrl_sequencer #(
    parameter int SamplePeriod_g = 100,
    parameter int Latency_g      = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [7:0]  Cfg_Ki,
    input  logic [11:0] Cfg_Kp,
    input  logic [7:0]  Cfg_ILim,
    input  logic        Cfg_Update,
    output logic        Cfg_Busy,
    input  logic        Adc_Valid,
    input  logic [11:0] Adc_Actual,
    input  logic [11:0] Target,
    output logic        Ctrl_Valid,
    output logic [11:0] Ctrl_Actual,
    output logic [11:0] Ctrl_Target,
    output logic [7:0]  Ctrl_Ki,
    output logic [11:0] Ctrl_Kp,
    output logic [7:0]  Ctrl_ILim,
    output logic        Ctrl_IntClr,
    input  logic        Res_Valid,
    input  logic [11:0] Res_Result,
    output logic        Out_Valid,
    output logic [11:0] Out_Result,
    output logic        Err_Timeout,
    output logic        Err_Overrun
);

    localparam int TimerW_c = (SamplePeriod_g > 1) ? $clog2(SamplePeriod_g) : 1;
    localparam int WdW_c    = $clog2(Latency_g + 1);
    localparam logic [TimerW_c-1:0] TimerLast_c = TimerW_c'(SamplePeriod_g - 1);
    localparam logic [WdW_c-1:0]    WdLast_c    = WdW_c'(Latency_g - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_APPLY
    } state_t;

    state_t                state_q, state_d;
    logic [TimerW_c-1:0]   timer_q, timer_d;
    logic [WdW_c-1:0]      wd_q, wd_d;
    logic                  fresh_q, fresh_d;
    logic [11:0]           adc_q, adc_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic [11:0]           ctrl_actual_q, ctrl_actual_d;
    logic [11:0]           ctrl_target_q, ctrl_target_d;
    logic [7:0]            shd_ki_q, shd_ki_d;
    logic [11:0]           shd_kp_q, shd_kp_d;
    logic [7:0]            shd_ilim_q, shd_ilim_d;
    logic [7:0]            act_ki_q, act_ki_d;
    logic [11:0]           act_kp_q, act_kp_d;
    logic [7:0]            act_ilim_q, act_ilim_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [11:0]           out_result_q, out_result_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_overrun_q, err_overrun_d;

    logic                  tick;
    logic                  issue;
    logic                  apply;
    logic                  overrun_set;
    logic                  timeout_set;
    logic                  pending;

    // Sample-rate timer: free-runs while enabled, parked at zero otherwise
    always_comb begin
        tick    = Enable && (timer_q == TimerLast_c);
        timer_d = timer_q;
        if (!Enable || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TimerW_c'(1);
        end
    end

    // Latest ADC sample and its freshness; a new sample on the issue cycle keeps the flag set
    always_comb begin
        adc_d   = adc_q;
        fresh_d = fresh_q;
        if (Adc_Valid) begin
            adc_d   = Adc_Actual;
            fresh_d = 1'b1;
        end else if (issue) begin
            fresh_d = 1'b0;
        end
    end

    // Sequencer FSM: next state, issue/apply decisions and error events
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        issue       = 1'b0;
        apply       = 1'b0;
        overrun_set = 1'b0;
        timeout_set = 1'b0;
        // A request arriving this cycle counts as pending so it is never missed
        pending     = busy_q || Cfg_Update;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_APPLY;
                end else if (Enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Gain update has priority; a coincident tick is silently dropped
                if (pending) begin
                    state_d = ST_APPLY;
                end else if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (fresh_q) begin
                        issue   = 1'b1;
                        wd_d    = '0;
                        state_d = ST_WAIT;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + WdW_c'(1);
                if (tick) begin
                    overrun_set = 1'b1;
                end
                // A missing result is treated as completion so sampling recovers
                if (Res_Valid || (wd_q == WdLast_c)) begin
                    timeout_set = !Res_Valid;
                    if (pending) begin
                        state_d = ST_DRAIN;
                    end else if (Enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                // Lets the registered result leave before the gains change
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = Enable ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow gains follow every request; active gains only move in APPLY
    always_comb begin
        shd_ki_d   = shd_ki_q;
        shd_kp_d   = shd_kp_q;
        shd_ilim_d = shd_ilim_q;
        act_ki_d   = act_ki_q;
        act_kp_d   = act_kp_q;
        act_ilim_d = act_ilim_q;
        busy_d     = busy_q;
        if (apply) begin
            act_ki_d   = shd_ki_q;
            act_kp_d   = shd_kp_q;
            act_ilim_d = shd_ilim_q;
            busy_d     = 1'b0;
        end
        // A request in the APPLY cycle itself stays pending for another APPLY
        if (Cfg_Update) begin
            shd_ki_d   = Cfg_Ki;
            shd_kp_d   = Cfg_Kp;
            shd_ilim_d = Cfg_ILim;
            busy_d     = 1'b1;
        end
    end

    // Controller-facing sample, forwarded result and sticky error flags
    always_comb begin
        ctrl_valid_d  = issue;
        ctrl_actual_d = ctrl_actual_q;
        ctrl_target_d = ctrl_target_q;
        if (issue) begin
            ctrl_actual_d = adc_q;
            ctrl_target_d = Target;
        end
        out_valid_d   = Res_Valid;
        out_result_d  = Res_Valid ? Res_Result : out_result_q;
        err_timeout_d = err_timeout_q || timeout_set;
        err_overrun_d = err_overrun_q || overrun_set;
    end

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            wd_q          <= '0;
            fresh_q       <= 1'b0;
            adc_q         <= '0;
            ctrl_valid_q  <= 1'b0;
            ctrl_actual_q <= '0;
            ctrl_target_q <= '0;
            shd_ki_q      <= '0;
            shd_kp_q      <= '0;
            shd_ilim_q    <= '0;
            act_ki_q      <= '0;
            act_kp_q      <= '0;
            act_ilim_q    <= '0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wd_q          <= wd_d;
            fresh_q       <= fresh_d;
            adc_q         <= adc_d;
            ctrl_valid_q  <= ctrl_valid_d;
            ctrl_actual_q <= ctrl_actual_d;
            ctrl_target_q <= ctrl_target_d;
            shd_ki_q      <= shd_ki_d;
            shd_kp_q      <= shd_kp_d;
            shd_ilim_q    <= shd_ilim_d;
            act_ki_q      <= act_ki_d;
            act_kp_q      <= act_kp_d;
            act_ilim_q    <= act_ilim_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

`ifdef OLO_FIX_SEQ_INT_CLEAR_EN
    logic intclr_q, intclr_d;

    // Integrator clear is registered so it lines up with the new active gains
    always_comb begin
        intclr_d = apply;
    end

    // Integrator clear register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            intclr_q <= 1'b0;
        end else begin
            intclr_q <= intclr_d;
        end
    end

    assign Ctrl_IntClr = intclr_q;
`else
    // Integrator keeps its state across gain updates
    assign Ctrl_IntClr = 1'b0;
`endif

    assign Cfg_Busy    = busy_q;
    assign Ctrl_Valid  = ctrl_valid_q;
    assign Ctrl_Actual = ctrl_actual_q;
    assign Ctrl_Target = ctrl_target_q;
    assign Ctrl_Ki     = act_ki_q;
    assign Ctrl_Kp     = act_kp_q;
    assign Ctrl_ILim   = act_ilim_q;
    assign Out_Valid   = out_valid_q;
    assign Out_Result  = out_result_q;
    assign Err_Timeout = err_timeout_q;
    assign Err_Overrun = err_overrun_q;

endmodule
